// File: rtl/map_loader_if.sv
// Game-map constants plus the loader's stream/write-port bundle.
// slave is the loader side; master is the byte source / map-memory side.
package map_loader_pkg;
  localparam int GAME_MAP_WIDTH  = 16;
  localparam int GAME_MAP_HEIGHT = 12;
  typedef logic [3:0] terrain_t;
endpackage

interface map_loader_if #(
  parameter int MAP_W = map_loader_pkg::GAME_MAP_WIDTH,
  parameter int MAP_H = map_loader_pkg::GAME_MAP_HEIGHT
) ();
  localparam int MAP_IDX_SIZE_X = (MAP_W > 1) ? $clog2(MAP_W) : 1;
  localparam int MAP_IDX_SIZE_Y = (MAP_H > 1) ? $clog2(MAP_H) : 1;

  logic                            in_valid;
  logic [7:0]                      in_data;
  logic                            in_ready;
  logic                            write_enable;
  logic [MAP_IDX_SIZE_X-1:0]       write_x;
  logic [MAP_IDX_SIZE_Y-1:0]       write_y;
  map_loader_pkg::terrain_t        write_data;

  modport slave (
    input  in_valid, in_data,
    output in_ready, write_enable, write_x, write_y, write_data
  );

  modport master (
    output in_valid, in_data,
    input  in_ready, write_enable, write_x, write_y, write_data
  );
endinterface

// File: rtl/map_loader.sv
// Decodes a run-length byte stream into raster-order game map writes,
// optionally sweeping the whole map to CLEAR_TERRAIN first.
module map_loader
  import map_loader_pkg::*;
#(
  parameter int       MAP_W          = GAME_MAP_WIDTH,
  parameter int       MAP_H          = GAME_MAP_HEIGHT,
  parameter int       NUM_TERRAIN    = 4,
  parameter terrain_t CLEAR_TERRAIN  = terrain_t'(0),
  parameter bit       CLEAR_ON_START = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_start,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic        error,
  map_loader_if.slave bus
);

  localparam int MAP_IDX_SIZE_X = (MAP_W > 1) ? $clog2(MAP_W) : 1;
  localparam int MAP_IDX_SIZE_Y = (MAP_H > 1) ? $clog2(MAP_H) : 1;
  localparam logic [MAP_IDX_SIZE_X-1:0] LAST_X = MAP_IDX_SIZE_X'(MAP_W - 1);
  localparam logic [MAP_IDX_SIZE_Y-1:0] LAST_Y = MAP_IDX_SIZE_Y'(MAP_H - 1);

  typedef enum logic [1:0] {IDLE, CLEAR, RECV, DONE} state_t;

  state_t                    state, next_state;
  logic [MAP_IDX_SIZE_X-1:0] cur_x, next_x;
  logic [MAP_IDX_SIZE_Y-1:0] cur_y, next_y;
  logic [4:0]                run_left;
  terrain_t                  run_code;
  logic                      err;

  logic last_cell, writing, ready, accept, start, illegal_code;

  assign last_cell    = (cur_x == LAST_X) && (cur_y == LAST_Y);
  assign start        = load_start && ((state == IDLE) || (state == DONE));
  assign accept       = ready && bus.in_valid && !abort;
  assign illegal_code = ({28'd0, bus.in_data[3:0]} >= $unsigned(NUM_TERRAIN));

  // Raster-order successor of the cursor; wraps to (0,0) after the last cell.
  always_comb begin
    next_x = cur_x + 1'b1;
    next_y = cur_y;
    if (cur_x == LAST_X) begin
      next_x = '0;
      next_y = (cur_y == LAST_Y) ? '0 : cur_y + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE: if (load_start) next_state = CLEAR_ON_START ? CLEAR : RECV;
      CLEAR:      if (abort) next_state = IDLE;
                  else if (last_cell) next_state = RECV;
      RECV:       if (abort) next_state = IDLE;
                  else if (writing && last_cell) next_state = DONE;
      default:    next_state = IDLE;
    endcase
  end

  // A byte may land while the final cell of the current run is being written,
  // so back-to-back runs need no bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_x    <= '0;
      cur_y    <= '0;
      run_left <= '0;
      run_code <= CLEAR_TERRAIN;
      err      <= 1'b0;
    end else if (start) begin
      cur_x    <= '0;
      cur_y    <= '0;
      run_left <= '0;
      err      <= 1'b0;
    end else if (!abort) begin
      if (state == CLEAR) begin
        cur_x <= next_x;
        cur_y <= next_y;
      end else if (state == RECV) begin
        if (writing) begin
          cur_x <= next_x;
          cur_y <= next_y;
        end
        if (accept) begin
          run_left <= {1'b0, bus.in_data[7:4]} + 5'd1;
          run_code <= illegal_code ? CLEAR_TERRAIN : terrain_t'(bus.in_data[3:0]);
          if (illegal_code) err <= 1'b1;
        end else if (writing && last_cell) begin
          run_left <= '0;
          if (run_left > 5'd1) err <= 1'b1;
        end else if (writing) begin
          run_left <= run_left - 5'd1;
        end
      end
    end
  end

  always_comb begin
    writing          = (state == CLEAR) || ((state == RECV) && (run_left != 5'd0));
    ready            = (state == RECV) &&
                       ((run_left == 5'd0) || ((run_left == 5'd1) && !last_cell));
    busy             = (state == CLEAR) || (state == RECV);
    done             = (state == DONE);
    error            = err;
    bus.in_ready     = ready;
    bus.write_enable = writing;
    bus.write_x      = cur_x;
    bus.write_y      = cur_y;
    bus.write_data   = (state == CLEAR) ? CLEAR_TERRAIN : run_code;
  end

endmodule

// File: tb/tb_map_loader.sv
// Directed bench for map_loader on a 4x2 map: one instance clears on start,
// the other goes straight to receive.
module tb_map_loader;
  import map_loader_pkg::*;

  localparam int MW = 4;
  localparam int MH = 2;

  logic clk = 1'b0;
  logic reset;
  logic load_a, abort_a, busy_a, done_a, error_a;
  logic load_b, abort_b, busy_b, done_b, error_b;
  int   total = 0;
  int   bad   = 0;

  map_loader_if #(.MAP_W(MW), .MAP_H(MH)) bus_a ();
  map_loader_if #(.MAP_W(MW), .MAP_H(MH)) bus_b ();

  map_loader #(.MAP_W(MW), .MAP_H(MH), .NUM_TERRAIN(4),
               .CLEAR_TERRAIN(terrain_t'(0)), .CLEAR_ON_START(1'b1)) dut_a (
    .clk(clk), .reset(reset), .load_start(load_a), .abort(abort_a),
    .busy(busy_a), .done(done_a), .error(error_a), .bus(bus_a.slave));

  map_loader #(.MAP_W(MW), .MAP_H(MH), .NUM_TERRAIN(4),
               .CLEAR_TERRAIN(terrain_t'(0)), .CLEAR_ON_START(1'b0)) dut_b (
    .clk(clk), .reset(reset), .load_start(load_b), .abort(abort_b),
    .busy(busy_b), .done(done_b), .error(error_b), .bus(bus_b.slave));

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [7:0] data);
    bus_b.in_valid = valid;
    bus_b.in_data  = data;
  endtask

  task automatic checkWrite(input bit use_a, input string tag, input logic we,
                            input int x, input int y, input int d, input logic rdy);
    if (use_a) begin
      checkOutput({tag, ".we"},  32'(bus_a.write_enable), 32'(we));
      checkOutput({tag, ".rdy"}, 32'(bus_a.in_ready), 32'(rdy));
      if (we) begin
        checkOutput({tag, ".x"}, 32'(bus_a.write_x), x);
        checkOutput({tag, ".y"}, 32'(bus_a.write_y), y);
        checkOutput({tag, ".d"}, 32'(bus_a.write_data), d);
      end
    end else begin
      checkOutput({tag, ".we"},  32'(bus_b.write_enable), 32'(we));
      checkOutput({tag, ".rdy"}, 32'(bus_b.in_ready), 32'(rdy));
      if (we) begin
        checkOutput({tag, ".x"}, 32'(bus_b.write_x), x);
        checkOutput({tag, ".y"}, 32'(bus_b.write_y), y);
        checkOutput({tag, ".d"}, 32'(bus_b.write_data), d);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    load_a = 1'b0; abort_a = 1'b0; load_b = 1'b0; abort_b = 1'b0;
    bus_a.in_valid = 1'b0; bus_a.in_data = 8'h00;
    applyStimulus(1'b0, 8'h00);
    step(); step();
    reset = 1'b0;

    // Reset state
    checkWrite(1'b1, "rst_a", 1'b0, 0, 0, 0, 1'b0);
    checkOutput("rst_a.x", 32'(bus_a.write_x), 0);
    checkOutput("rst_a.y", 32'(bus_a.write_y), 0);
    checkOutput("rst_a.d", 32'(bus_a.write_data), 0);
    checkOutput("rst_a.busy", 32'(busy_a), 0);
    checkOutput("rst_a.done", 32'(done_a), 0);
    checkOutput("rst_a.err", 32'(error_a), 0);
    checkOutput("rst_b.busy", 32'(busy_b), 0);

    // Clear sweep on instance A
    load_a = 1'b1; step(); load_a = 1'b0;
    for (int i = 0; i < MW * MH; i++) begin
      checkWrite(1'b1, $sformatf("clr%0d", i), 1'b1, i % MW, i / MW, 0, 1'b0);
      checkOutput($sformatf("clr%0d.busy", i), 32'(busy_a), 1);
      step();
    end
    checkWrite(1'b1, "clr_recv", 1'b0, 0, 0, 0, 1'b1);
    checkOutput("clr_recv.busy", 32'(busy_a), 1);
    abort_a = 1'b1; step(); abort_a = 1'b0;
    checkOutput("abort_a.busy", 32'(busy_a), 0);
    checkOutput("abort_a.rdy", 32'(bus_a.in_ready), 0);

    // load_start while busy must not restart the sweep
    load_a = 1'b1; step(); load_a = 1'b0;
    step();
    load_a = 1'b1; step(); load_a = 1'b0;
    checkWrite(1'b1, "busy_load", 1'b1, 2, 0, 0, 1'b0);
    abort_a = 1'b1; step(); abort_a = 1'b0;

    // Synchronous reset mid-clear at cell (2,0)
    load_a = 1'b1; step(); load_a = 1'b0;
    step(); step();
    checkWrite(1'b1, "pre_rst", 1'b1, 2, 0, 0, 1'b0);
    reset = 1'b1; step();
    checkWrite(1'b1, "mid_rst", 1'b0, 0, 0, 0, 1'b0);
    checkOutput("mid_rst.x", 32'(bus_a.write_x), 0);
    checkOutput("mid_rst.d", 32'(bus_a.write_data), 0);
    checkOutput("mid_rst.busy", 32'(busy_a), 0);
    checkOutput("mid_rst.done", 32'(done_a), 0);
    reset = 1'b0; step();
    checkOutput("post_rst.we", 32'(bus_a.write_enable), 0);

    // Back-to-back runs 0x32 then 0x31 on instance B
    load_b = 1'b1; step(); load_b = 1'b0;
    checkWrite(1'b0, "b2b_recv", 1'b0, 0, 0, 0, 1'b1);
    applyStimulus(1'b1, 8'h32); step();
    applyStimulus(1'b1, 8'h31);
    for (int i = 0; i < MW * MH; i++) begin
      checkWrite(1'b0, $sformatf("b2b%0d", i), 1'b1, i % MW, i / MW,
                 (i < 4) ? 2 : 1, i == 3);
      step();
      if (i == 3) applyStimulus(1'b0, 8'h00);
    end
    checkOutput("b2b.done", 32'(done_b), 1);
    checkOutput("b2b.err", 32'(error_b), 0);
    checkWrite(1'b0, "b2b_end", 1'b0, 0, 0, 0, 1'b0);

    // 16-cell run overflows an 8-cell map
    load_b = 1'b1; step(); load_b = 1'b0;
    checkOutput("ovf.err_clr", 32'(error_b), 0);
    applyStimulus(1'b1, 8'hF3); step();
    for (int i = 0; i < MW * MH; i++) begin
      checkWrite(1'b0, $sformatf("ovf%0d", i), 1'b1, i % MW, i / MW, 3, 1'b0);
      checkOutput($sformatf("ovf%0d.err", i), 32'(error_b), 0);
      step();
    end
    checkOutput("ovf.done", 32'(done_b), 1);
    checkOutput("ovf.err", 32'(error_b), 1);
    step();
    checkWrite(1'b0, "ovf_hold", 1'b0, 0, 0, 0, 1'b0);
    checkOutput("ovf_hold.done", 32'(done_b), 1);
    applyStimulus(1'b0, 8'h00);

    // Illegal code 7 replaced by clear terrain, then 7 cells of code 0
    load_b = 1'b1; step(); load_b = 1'b0;
    checkOutput("ill.err_clr", 32'(error_b), 0);
    applyStimulus(1'b1, 8'h07); step();
    applyStimulus(1'b1, 8'h60);
    for (int i = 0; i < MW * MH; i++) begin
      checkWrite(1'b0, $sformatf("ill%0d", i), 1'b1, i % MW, i / MW, 0, i == 0);
      checkOutput($sformatf("ill%0d.err", i), 32'(error_b), 1);
      step();
      if (i == 0) applyStimulus(1'b0, 8'h00);
    end
    checkOutput("ill.done", 32'(done_b), 1);
    checkOutput("ill.err", 32'(error_b), 1);

    // Abort beats in_valid; err survives abort, cleared by next load
    load_b = 1'b1; step(); load_b = 1'b0;
    checkOutput("abt.err_clr", 32'(error_b), 0);
    applyStimulus(1'b1, 8'h24); step();
    applyStimulus(1'b0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      checkWrite(1'b0, $sformatf("abt%0d", i), 1'b1, i, 0, 0, i == 2);
      checkOutput($sformatf("abt%0d.err", i), 32'(error_b), 1);
      step();
    end
    checkWrite(1'b0, "abt_gap", 1'b0, 0, 0, 0, 1'b1);
    checkOutput("abt_gap.x", 32'(bus_b.write_x), 3);
    abort_b = 1'b1; applyStimulus(1'b1, 8'h12); step(); abort_b = 1'b0;
    checkWrite(1'b0, "abt_idle", 1'b0, 0, 0, 0, 1'b0);
    checkOutput("abt_idle.busy", 32'(busy_b), 0);
    checkOutput("abt_idle.done", 32'(done_b), 0);
    checkOutput("abt_idle.err", 32'(error_b), 1);
    step();
    checkWrite(1'b0, "abt_idle2", 1'b0, 0, 0, 0, 1'b0);
    applyStimulus(1'b0, 8'h00);
    load_b = 1'b1; step(); load_b = 1'b0;
    checkWrite(1'b0, "restart", 1'b0, 0, 0, 0, 1'b1);
    checkOutput("restart.x", 32'(bus_b.write_x), 0);
    checkOutput("restart.y", 32'(bus_b.write_y), 0);
    checkOutput("restart.err", 32'(error_b), 0);
    checkOutput("restart.busy", 32'(busy_b), 1);
    step();
    checkOutput("restart.we", 32'(bus_b.write_enable), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
